pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of operand, immediate and PC fields.
REQ-002 SHALL have parameter REG_W, default 5, width of destination-register index.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream beat valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-008 SHALL have port send_nop  input  1  convert the accepted beat into a bubble.
REQ-009 SHALL have port flush  input  1  discard all held beats.
REQ-010 SHALL have ports in_pc, in_src_a, in_src_b, in_imm  input  DATA_W each  upstream payload.
REQ-011 SHALL have port in_wreg  input  REG_W  destination register index.
REQ-012 SHALL have port out_valid  output  1  downstream beat valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-014 SHALL have ports out_pc, out_src_a, out_src_b, out_wdata, out_imm  output  DATA_W each; out_wreg  output  REG_W  registered payload.
REQ-015 SHALL have port out_is_nop  output  1  current output beat is a bubble.
REQ-016 SHALL have port stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-017 SHALL hold two entries: main (drives outputs) and skid; each with a valid bit.
REQ-018 SHALL drive in_ready = NOT skid.valid (combinational from registered state only).
REQ-019 SHALL accept a beat when in_valid AND in_ready; accepted beat appears on outputs the next cycle when main is empty or being popped (latency 1).
REQ-020 SHALL pop main when out_valid AND out_ready; on pop, skid (if valid) moves to main in the same edge, else an accepted beat loads main.
REQ-021 SHALL load an accepted beat into skid when main is valid and not popped that cycle.
REQ-022 SHALL, on an accepted beat with send_nop=1, store src_a, src_b, wdata, imm, wreg as 0, keep pc, set is_nop=1; the bubble occupies a slot and asserts out_valid.
REQ-023 SHALL set out_wdata equal to the stored src_b of the same beat.
REQ-024 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL preserve beat order; no beat duplicated or dropped except by flush.
REQ-026 SHALL, on flush=1, clear main and skid valid bits next cycle; flush dominates a simultaneous accept (that beat dropped) and a simultaneous pop.
REQ-027 SHALL leave payload registers unchanged on flush; only valid bits clear.
REQ-028 SHALL increment stall_cnt each cycle out_valid=1 and out_ready=0, saturating at 2^CNT_W-1; flush does not clear it.
REQ-029 SHALL ignore send_nop when no beat is accepted.

Reset
REQ-030 SHALL, when rst_n=0 at a posedge, clear main/skid valid, all payload outputs, out_is_nop and stall_cnt to 0; in_ready=1 the following cycle.
REQ-031 SHALL give reset priority over flush, accept and pop; reset mid-transfer drops all held beats.

Verification
REQ-032 Stream: in_valid=1, out_ready=1, in_pc=0x100,0x104,0x108 -> same values on out_pc one cycle later each, stall_cnt=0.
REQ-033 Backpressure: out_ready=0 for 3 cycles with beats 0x200,0x204 sent -> in_ready=0 after 2nd beat, outputs hold 0x200, stall_cnt=3; release -> 0x200 then 0x204.
REQ-034 Bubble: send_nop=1 with in_pc=0x300, in_src_b=0xABCD -> out_pc=0x300, out_src_b=0, out_wdata=0, out_is_nop=1, out_valid=1.
REQ-035 Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, new beat not seen.
REQ-036 Saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15; rst_n=0 one cycle -> stall_cnt=0, out_valid=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with bubble insert, flush and stall counter
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              send_nop,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_src_a,
  input  logic [DATA_W-1:0] in_src_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_W-1:0]  in_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_src_a,
  output logic [DATA_W-1:0] out_src_b,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_wreg,
  output logic              out_is_nop,
  output logic [CNT_W-1:0]  stall_cnt
);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  wreg;
    logic              nop;
  } beat_t;
  logic  m_valid, s_valid, acc, pop;
  beat_t m, s, inb;
  assign in_ready = ~s_valid;
  assign acc      = in_valid & ~s_valid;
  assign pop      = m_valid & out_ready;
  // a bubble keeps its pc so downstream can still attribute it
  always_comb begin
    inb.pc   = in_pc;
    inb.a    = send_nop ? '0 : in_src_a;
    inb.b    = send_nop ? '0 : in_src_b;
    inb.imm  = send_nop ? '0 : in_imm;
    inb.wreg = send_nop ? '0 : in_wreg;
    inb.nop  = send_nop;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid   <= 1'b0;
      s_valid   <= 1'b0;
      m         <= '0;
      s         <= '0;
      stall_cnt <= '0;
    end else begin
      if (m_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        m_valid <= 1'b0;
        s_valid <= 1'b0;
      end else if (!m_valid || pop) begin
        m_valid <= s_valid | acc;
        if (s_valid) begin
          m       <= s;
          s_valid <= 1'b0;
        end else if (acc) begin
          m <= inb;
        end
      end else if (acc) begin
        s       <= inb;
        s_valid <= 1'b1;
      end
    end
  end
  assign out_valid  = m_valid;
  assign out_pc     = m.pc;
  assign out_src_a  = m.a;
  assign out_src_b  = m.b;
  assign out_wdata  = m.b;
  assign out_imm    = m.imm;
  assign out_wreg   = m.wreg;
  assign out_is_nop = m.nop;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg against a two-slot queue model
module tb_pipe_stage_reg;
  localparam int DW = 32, RW = 5, CW = 4;
  localparam int SMAX = (1 << CW) - 1;
  typedef struct {
    logic [DW-1:0] pc, a, b, imm;
    logic [RW-1:0] wreg;
    logic          nop;
  } beat_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, send_nop = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_is_nop;
  logic [DW-1:0] in_pc = '0, in_src_a = '0, in_src_b = '0, in_imm = '0;
  logic [RW-1:0] in_wreg = '0;
  logic [DW-1:0] out_pc, out_src_a, out_src_b, out_wdata, out_imm;
  logic [RW-1:0] out_wreg;
  logic [CW-1:0] stall_cnt;
  beat_t q[$];
  int pend = 0, sc = 0, checks = 0, errors = 0;

  pipe_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .send_nop(send_nop),
    .flush(flush), .in_pc(in_pc), .in_src_a(in_src_a), .in_src_b(in_src_b), .in_imm(in_imm),
    .in_wreg(in_wreg), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_src_a(out_src_a), .out_src_b(out_src_b), .out_wdata(out_wdata), .out_imm(out_imm),
    .out_wreg(out_wreg), .out_is_nop(out_is_nop), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle of stimulus; an accepted, unflushed beat is pushed as expected output
  task automatic cyc(input logic r, v, nop, fl, ordy, input logic [DW-1:0] pc);
    beat_t e;
    @(posedge clk);
    #1;
    rst_n = r; in_valid = v; send_nop = nop; flush = fl; out_ready = ordy; in_pc = pc;
    in_src_a = $urandom; in_src_b = $urandom; in_imm = $urandom; in_wreg = RW'($urandom);
    pend = 0;
    if (r && v && !fl && q.size() < 2) begin
      e.pc = pc; e.nop = nop;
      e.a = nop ? '0 : in_src_a; e.b = nop ? '0 : in_src_b;
      e.imm = nop ? '0 : in_imm; e.wreg = nop ? '0 : in_wreg;
      q.push_back(e);
      pend = 1;
    end
  endtask

  always @(negedge clk) begin
    automatic int held = q.size() - pend;
    automatic beat_t e;
    chk("out_valid", 160'(out_valid), 160'(held > 0));
    chk("in_ready", 160'(in_ready), 160'(held < 2));
    chk("stall_cnt", 160'(stall_cnt), 160'(sc));
    if (out_valid && out_ready && held > 0) begin
      e = q.pop_front();
      chk("beat_pc", 160'(out_pc), 160'(e.pc));
      chk("beat_payload", {out_src_a, out_src_b, out_wdata, out_imm, out_wreg, out_is_nop},
          {e.a, e.b, e.b, e.imm, e.wreg, e.nop});
    end
    if (!rst_n || flush) q.delete();
    if (!rst_n) sc = 0;
    else if (held > 0 && !out_ready && sc < SMAX) sc++;
    pend = 0;
  end

  initial begin
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("reset_payload", {out_pc, out_src_b, out_wdata, out_is_nop}, '0);
    // streaming
    cyc(1, 1, 0, 0, 1, 32'h100);
    cyc(1, 1, 0, 0, 1, 32'h104);
    cyc(1, 1, 0, 0, 1, 32'h108);
    chk("stream_pc", 160'(out_pc), 160'h104);
    cyc(1, 0, 0, 0, 1, 0);
    chk("stream_stall", 160'(stall_cnt), 160'h0);
    // backpressure
    cyc(1, 1, 0, 0, 0, 32'h200);
    cyc(1, 1, 0, 0, 0, 32'h204);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("bp_stall", 160'(stall_cnt), 160'h3);
    chk("bp_ready", 160'(in_ready), 160'h0);
    chk("bp_hold", 160'(out_pc), 160'h200);
    cyc(1, 0, 0, 0, 1, 0);
    chk("bp_second", 160'(out_pc), 160'h204);
    cyc(1, 0, 0, 0, 1, 0);
    // bubble
    cyc(1, 1, 1, 0, 0, 32'h300);
    cyc(1, 0, 0, 0, 0, 0);
    chk("nop_fields", {out_pc, out_src_b, out_wdata, out_is_nop, out_valid},
        {32'h300, 32'h0, 32'h0, 1'b1, 1'b1});
    cyc(1, 0, 0, 0, 1, 0);
    // flush with both entries full and a pending beat
    cyc(1, 1, 0, 0, 0, 32'h400);
    cyc(1, 1, 0, 0, 0, 32'h404);
    cyc(1, 1, 0, 1, 0, 32'h408);
    cyc(1, 0, 0, 0, 1, 0);
    chk("flush_state", {out_valid, in_ready}, 2'b01);
    cyc(1, 1, 0, 1, 1, 32'h500);
    cyc(1, 0, 0, 0, 1, 0);
    chk("flush_drop", 160'(out_valid), 160'h0);
    // saturation, then reset
    cyc(1, 1, 0, 0, 0, 32'h600);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("sat_cnt", 160'(stall_cnt), 160'(SMAX));
    cyc(0, 1, 0, 0, 0, 32'h700);
    cyc(1, 0, 0, 0, 1, 0);
    chk("rst_state", {stall_cnt, out_valid, in_ready, out_pc}, {4'h0, 1'b0, 1'b1, 32'h0});
    // randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
          $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6, $urandom);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    chk("drain", 160'(q.size()), 160'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
